// File: rtl/serializador_pkg.sv
// Shared types and sizing helpers for the serializador block.
package serializador_pkg;

  // Default word width in bits.
  localparam int N_DEFAULT = 4;

  // Frame kind currently on the serial line.
  typedef enum logic {
    IDLE_FRAME = 1'b0,
    DATA_FRAME = 1'b1
  } state_t;

  // Bit-counter width for a frame of n bits (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializador_fifo.sv
// Two-entry input FIFO for the serializador (built only with SERIALIZADOR_FIFO_EN).
// Push and pop may occur in the same cycle; push when full and pop when empty are ignored.
module serializador_fifo #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] dato,
  input  logic         pop,
  output logic [W-1:0] cabeza,
  output logic         llena,
  output logic         vacia
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cuenta;
  logic         do_push;
  logic         do_pop;

  assign llena   = (cuenta == 2'd2);
  assign vacia   = (cuenta == 2'd0);
  assign cabeza  = mem[rd_ptr];
  assign do_push = push && !llena;
  assign do_pop  = pop && !vacia;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cuenta <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= dato;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cuenta <= cuenta + 2'd1;
        2'b01:   cuenta <= cuenta - 2'd1;
        default: cuenta <= cuenta;
      endcase
    end
  end

endmodule

// File: rtl/serializador.sv
// Parallel-to-serial converter emitting a gapless stream of N-bit frames, LSB first.
// Optional 2-entry input FIFO enabled by defining SERIALIZADOR_FIFO_EN.
//
// state      | meaning
// IDLE_FRAME | current frame carries all zeros
// DATA_FRAME | current frame carries an accepted word
module serializador
  import serializador_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] dato_in,
  input  logic         valido_in,
  output logic         listo_out,
  output logic         salida_serie,
  output logic         inicio_palabra,
  output logic         ocupado,
  output logic [15:0]  palabras_tx
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0] cnt;
  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  sreg;
  logic [N-1:0]  sreg_nxt;
  logic          frontera;
  logic          cargar;
  logic [N-1:0]  palabra_sig;

  assign frontera = (cnt == CNT_LAST);

`ifdef SERIALIZADOR_FIFO_EN
  logic         fifo_llena;
  logic         fifo_vacia;
  logic [N-1:0] fifo_cabeza;

  // No bypass: a word pushed at a boundary waits for the next one.
  assign listo_out   = !fifo_llena;
  assign cargar      = frontera && !fifo_vacia;
  assign palabra_sig = fifo_cabeza;

  serializador_fifo #(
    .W (N)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (valido_in && listo_out),
    .dato   (dato_in),
    .pop    (cargar),
    .cabeza (fifo_cabeza),
    .llena  (fifo_llena),
    .vacia  (fifo_vacia)
  );
`else
  // Words are only taken on the boundary cycle; anything else is dropped.
  assign listo_out   = frontera;
  assign cargar      = frontera && valido_in;
  assign palabra_sig = dato_in;
`endif

  assign salida_serie   = sreg[0];
  assign inicio_palabra = (cnt == '0);
  assign ocupado        = (state == DATA_FRAME);

  // Next frame selection at the boundary, shifting otherwise.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg >> 1;
    if (frontera) begin
      if (cargar) begin
        state_nxt = DATA_FRAME;
        sreg_nxt  = palabra_sig;
      end else begin
        state_nxt = IDLE_FRAME;
        sreg_nxt  = '0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE_FRAME;
    end else begin
      state <= state_nxt;
    end
  end

  // Bit counter, shift register and completed-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sreg        <= '0;
      palabras_tx <= 16'd0;
    end else begin
      cnt  <= frontera ? '0 : cnt + CW'(1);
      sreg <= sreg_nxt;
      if (frontera && (state == DATA_FRAME)) begin
        palabras_tx <= palabras_tx + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Self-checking bench for serializador (N=4) against a frame-level reference model.
module tb_serializador;
  import serializador_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] dato_in;
  logic         valido_in;
  logic         listo_out;
  logic         salida_serie;
  logic         inicio_palabra;
  logic         ocupado;
  logic [15:0]  palabras_tx;

  serializador #(.N(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dato_in        (dato_in),
    .valido_in      (valido_in),
    .listo_out      (listo_out),
    .salida_serie   (salida_serie),
    .inicio_palabra (inicio_palabra),
    .ocupado        (ocupado),
    .palabras_tx    (palabras_tx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: cycle index since reset, the word carried by the current frame,
  // completed data frames, and the pending-word queue when the FIFO is built.
  int           m_t;
  logic [N-1:0] m_word;
  bit           m_data;
  logic [15:0]  m_words;
  logic [N-1:0] m_q[$];
  logic [N-1:0] rx_sh;
  logic [N-1:0] rx_q[$];

  function automatic void model_reset();
    m_t     = 0;
    m_word  = '0;
    m_data  = 1'b0;
    m_words = 16'd0;
    m_q.delete();
    rx_sh   = '0;
  endfunction

  function automatic bit m_listo();
`ifdef SERIALIZADOR_FIFO_EN
    return m_q.size() < 2;
`else
    return (m_t % N) == N - 1;
`endif
  endfunction

  // Called at a falling edge: check this cycle's outputs, drive inputs, advance model.
  task automatic step(input logic v, input logic [N-1:0] d);
    int ph;
    bit acc;
    ph = m_t % N;
    chk("salida_serie", salida_serie, m_word[ph]);
    chk("inicio_palabra", inicio_palabra, ph == 0);
    chk("ocupado", ocupado, m_data);
    chk("listo_out", listo_out, m_listo());
    chk("palabras_tx", palabras_tx, m_words);
    rx_sh[ph] = salida_serie;
    if (ph == N - 1) rx_q.push_back(rx_sh);
    valido_in = v;
    dato_in   = d;
    acc = v && m_listo();
    if (ph == N - 1) begin
      if (m_data) m_words = m_words + 16'd1;
`ifdef SERIALIZADOR_FIFO_EN
      if (m_q.size() > 0) begin
        m_word = m_q.pop_front();
        m_data = 1'b1;
      end else begin
        m_word = '0;
        m_data = 1'b0;
      end
`else
      if (acc) begin
        m_word = d;
        m_data = 1'b1;
      end else begin
        m_word = '0;
        m_data = 1'b0;
      end
`endif
    end
`ifdef SERIALIZADOR_FIFO_EN
    if (acc) m_q.push_back(d);
`endif
    m_t++;
    @(negedge clk);
  endtask

  task automatic send_at_boundary(input logic [N-1:0] w);
    while ((m_t % N) != N - 1) step(1'b0, N'($urandom));
    step(1'b1, w);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_salida"}, salida_serie, 1'b0);
    chk({tag, "_inicio"}, inicio_palabra, 1'b1);
    chk({tag, "_ocupado"}, ocupado, 1'b0);
    chk({tag, "_palabras"}, palabras_tx, 16'd0);
    chk({tag, "_listo"}, listo_out, m_listo());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n     = 1'b0;
    valido_in = 1'b0;
    dato_in   = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle stream after reset release.
    repeat (12) step(1'b0, '0);

    // Single word 1011 at a boundary.
    send_at_boundary(4'b1011);
    repeat (8) step(1'b0, '0);
    chk("one_word_count", palabras_tx, 16'd1);

    // Back-to-back words with loopback into a modulo-N receiver.
    rx_q.delete();
    send_at_boundary(4'hA);
    send_at_boundary(4'h5);
    repeat (12) step(1'b0, '0);
    found = 1'b0;
    for (int i = 0; i + 1 < rx_q.size(); i++)
      if (rx_q[i] == 4'hA && rx_q[i+1] == 4'h5) found = 1'b1;
    chk("loopback_A_then_5", found, 1'b1);

    // Word offered off-boundary.
    while ((m_t % N) != 1) step(1'b0, '0);
    step(1'b1, 4'h9);
    repeat (12) step(1'b0, '0);

    // Random traffic.
    repeat (300) step(1'($urandom_range(0, 1)), N'($urandom));
    repeat (12) step(1'b0, '0);

    // Reset in the middle of a data frame (bit counter at 2).
    send_at_boundary(4'hF);
    while ((m_t % N) != 2) step(1'b0, '0);
    chk("pre_reset_ocupado", ocupado, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_values("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b0, '0);
    send_at_boundary(4'h6);
    repeat (8) step(1'b0, '0);

    // Word counter wrap from 16'hFFFF.
    force dut.palabras_tx = 16'hFFFF;
    #1;
    release dut.palabras_tx;
    m_words = 16'hFFFF;
    send_at_boundary(4'h3);
    repeat (8) step(1'b0, '0);
    chk("wrap_to_zero", palabras_tx, 16'h0000);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
